hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline hazard detector. Tracks pending register writes with per-register countdown counters and control-transfer penalties with a small FSM; it does not compare raw stage instructions.
- Sits beside the IF/ID pipeline register. Drives the IF/PC stall.
- Adds an optional forwarding mode, ID-stage flush recovery and a stall performance counter.

Parameters:
- INSTR_W, 16, instruction width; opcode is [INSTR_W-1:INSTR_W-4].
- NREGS, 16, architectural register count; index width RA_W = clog2(NREGS).
- ALU_LAT, 2, stall cycles after issue of a non-load writer when FWD_EN=0 (producer in ID, EX).
- LOAD_LAT, 2, stall cycles after issue of LW (applies in both modes).
- FWD_EN, 0, 1 = ALU/CALL/RET results forwarded (latency 0), only load-use stalls.
- CALL_PEN, 1, stall cycles after CALL issues.
- RET_PEN, 3, stall cycles after RET issues (RET in ID, EX, MEM).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- if_instr  in  INSTR_W  instruction held in IF.
- if_valid  in  1  if_instr is a real instruction; 0 means bubble.
- flush_id  in  1  instruction that issued last cycle (now in ID) is squashed.
- stall  out  1  hold PC and IF/ID; combinational.
- issue  out  1  if_valid & ~stall; the IF instruction enters ID at the next edge.
- stall_cause  out  2  0 none, 1 data, 2 control, 3 both.
- busy_mask  out  NREGS  bit r = counter[r] != 0; registered.
- stall_cycles  out  CNT_W  saturating count of cycles with stall=1.

Behaviour:
- Reset (rst=1 at an edge): all counters 0; FSM IDLE; busy_mask=0; stall_cycles=0; the save register is invalid. Combinationally, stall=0 and stall_cause=0 whenever counters and FSM are idle.
- Source decode (opcode constants come from the shared opcode header):
  - Default: rs1=[7:4], rs2=[3:0].
  - INC/SRA/SRL/SLL: rs1 only.
  - SW: rs1=[11:8], rs2=14.
  - LW: rs2=14 only.
  - LHB/LLB: rs1=[11:8] only.
  - B: no sources.
  - CALL/RET: rs1=15 only.
- Destination decode: none for SW and B; 15 for CALL and RET; [11:8] otherwise. Register 0 is never a source hazard and never gets a counter.
- Data hazard: if_valid and any used source s!=0 with counter[s]!=0.
- Counter update, each edge:
  - Every nonzero counter decrements by 1.
  - On issue with a destination d!=0, counter[d] loads the latency: LOAD_LAT for LW; for all other writers, ALU_LAT if FWD_EN=0, else 0.
  - The load overrides the decrement, even when the old value was larger.
- Flush save: on issue, store (d, old counter[d] decremented by 1 and floored at 0, valid) in a one-entry save register.
  - flush_id=1 in the next cycle with the save register valid: counter[d] <= max(saved-1, 0).
  - The save register is valid for exactly one cycle after issue.
  - flush_id with the save register invalid has no effect on counters.
- Control FSM:
  - States: IDLE, WAIT(pcnt).
  - Issue of CALL goes to WAIT with pcnt=CALL_PEN; issue of RET goes to WAIT with pcnt=RET_PEN.
  - Each cycle in WAIT asserts a control stall and decrements pcnt; pcnt reaching 1 returns to IDLE.
  - flush_id while in WAIT on the first penalty cycle returns to IDLE at once; the stall is still asserted that cycle.
- Combined cause:
  - stall = data | control.
  - stall_cause bit0 = data, bit1 = control.
  - stall_cycles increments when stall=1, saturating at all ones (no wrap).
- if_valid=0: no data hazard is evaluated, but a control stall is still reported.
- Reset mid-penalty or mid-count: everything clears at that edge; no residual stall.

Decomposition:
- Shared package/header: opcode constants (existing opcode header), source/destination decode helper functions, stall_cause encodings.
- One sub-module is natural: hazard_reg_counter, one countdown counter per register with load/decrement/restore. Instantiate it NREGS-1 times with a generate loop.

Test Plan:
- ADD r3←r1,r2 issues at t; ADD r4←r3,r3 in IF → stall=1 at t+1 and t+2, issue at t+3; stall_cause=1; stall_cycles=2.
- FWD_EN=1: same sequence → no stall. LW r5 then ADD r6←r5,r5 → 2 stall cycles.
- RET issues at t; independent instruction in IF → stall at t+1..t+3 with stall_cause=2. CALL → stall at t+1 only.
- ADD r7 issues at t, flush_id=1 at t+1 → busy_mask[7]=0 after t+1, and a reader of r7 issues at t+2. Also: an older pending r7 count of 2 is restored to 0 at t+2.
- Reader of r0, and an SW using r14 while an LW targeting r0 is pending → no stall from r0; SW stalls while r14 is busy.
- rst asserted during the RET penalty and an r9 count → stall=0 and busy_mask=0 after the edge; force stall_cycles to its maximum → holds at all ones.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared opcode map, operand decode helpers and stall-cause encodings for
// the pipeline hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int unsigned OPC_W = 4;
    localparam int unsigned FLD_W = 4;

    localparam logic [OPC_W-1:0] OP_ADD    = 4'h0;
    localparam logic [OPC_W-1:0] OP_PADDSB = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB    = 4'h2;
    localparam logic [OPC_W-1:0] OP_AND    = 4'h3;
    localparam logic [OPC_W-1:0] OP_NOR    = 4'h4;
    localparam logic [OPC_W-1:0] OP_SLL    = 4'h5;
    localparam logic [OPC_W-1:0] OP_SRL    = 4'h6;
    localparam logic [OPC_W-1:0] OP_SRA    = 4'h7;
    localparam logic [OPC_W-1:0] OP_LW     = 4'h8;
    localparam logic [OPC_W-1:0] OP_SW     = 4'h9;
    localparam logic [OPC_W-1:0] OP_LHB    = 4'hA;
    localparam logic [OPC_W-1:0] OP_LLB    = 4'hB;
    localparam logic [OPC_W-1:0] OP_B      = 4'hC;
    localparam logic [OPC_W-1:0] OP_CALL   = 4'hD;
    localparam logic [OPC_W-1:0] OP_RET    = 4'hE;
    localparam logic [OPC_W-1:0] OP_INC    = 4'hF;

    // Memory ops address through r14; CALL/RET use r15 as the link register
    localparam logic [FLD_W-1:0] REG_BASE = 4'd14;
    localparam logic [FLD_W-1:0] REG_LINK = 4'd15;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_DATA = 2'd1;
    localparam logic [1:0] CAUSE_CTRL = 2'd2;
    localparam logic [1:0] CAUSE_BOTH = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } ctrl_state_e;

    typedef struct packed {
        logic             use1;
        logic [FLD_W-1:0] rs1;
        logic             use2;
        logic [FLD_W-1:0] rs2;
    } src_t;

    typedef struct packed {
        logic             valid;
        logic [FLD_W-1:0] rd;
    } dst_t;

    function automatic src_t decode_src(input logic [OPC_W-1:0] op,
                                        input logic [3*FLD_W-1:0] f);
        src_t s;
        s.use1 = 1'b1;
        s.rs1  = f[2*FLD_W-1:FLD_W];
        s.use2 = 1'b1;
        s.rs2  = f[FLD_W-1:0];
        case (op)
            OP_INC, OP_SRA, OP_SRL, OP_SLL: begin
                s.use2 = 1'b0;
                s.rs2  = '0;
            end
            OP_SW: begin
                s.rs1 = f[3*FLD_W-1:2*FLD_W];
                s.rs2 = REG_BASE;
            end
            OP_LW: begin
                s.use1 = 1'b0;
                s.rs1  = '0;
                s.rs2  = REG_BASE;
            end
            OP_LHB, OP_LLB: begin
                s.rs1  = f[3*FLD_W-1:2*FLD_W];
                s.use2 = 1'b0;
                s.rs2  = '0;
            end
            OP_B: begin
                s = '0;
            end
            OP_CALL, OP_RET: begin
                s.rs1  = REG_LINK;
                s.use2 = 1'b0;
                s.rs2  = '0;
            end
            default: ;
        endcase
        return s;
    endfunction

    // r0 is hardwired, so a write to it never creates a pending result
    function automatic dst_t decode_dst(input logic [OPC_W-1:0] op,
                                        input logic [FLD_W-1:0] rd_fld);
        dst_t d;
        case (op)
            OP_SW, OP_B:      d.rd = '0;
            OP_CALL, OP_RET:  d.rd = REG_LINK;
            default:          d.rd = rd_fld;
        endcase
        d.valid = (d.rd != '0);
        return d;
    endfunction

endpackage

// File: rtl/hazard_reg_counter.sv
// Per-register pending-write countdown: decrements to zero, with restore
// (flush recovery) and issue load, where load has the final say.
module hazard_reg_counter #(
    parameter int unsigned CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          restore_i,
    input  logic [CW-1:0] restore_val_i,
    output logic [CW-1:0] cnt_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        if (restore_i) begin
            cnt_d = restore_val_i;
        end
        if (load_i) begin
            cnt_d = load_val_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based IF/PC stall generation: per-register write countdowns for
// data hazards, a penalty FSM for CALL/RET, ID flush recovery and stall count.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned NREGS    = 16,
    parameter int unsigned ALU_LAT  = 2,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned FWD_EN   = 0,
    parameter int unsigned CALL_PEN = 1,
    parameter int unsigned RET_PEN  = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic               if_valid,
    input  logic               flush_id,
    output logic               stall,
    output logic               issue,
    output logic [1:0]         stall_cause,
    output logic [NREGS-1:0]   busy_mask,
    output logic [CNT_W-1:0]   stall_cycles
);

    localparam int unsigned RA_W    = $clog2(NREGS);
    localparam int unsigned ALU_EFF = (FWD_EN != 0) ? 0 : ALU_LAT;
    localparam int unsigned LAT_MAX = (LOAD_LAT > ALU_EFF) ? LOAD_LAT : ALU_EFF;
    localparam int unsigned LAT_W   = (LAT_MAX < 1) ? 1 : $clog2(LAT_MAX + 1);
    localparam int unsigned PEN_MAX = (CALL_PEN > RET_PEN) ? CALL_PEN : RET_PEN;
    localparam int unsigned PEN_W   = (PEN_MAX < 1) ? 1 : $clog2(PEN_MAX + 1);

    function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] v);
        return (v != '0) ? v - LAT_W'(1) : '0;
    endfunction

    logic [OPC_W-1:0] opc;
    src_t             src;
    dst_t             dst;
    logic [RA_W-1:0]  rs1_idx;
    logic [RA_W-1:0]  rs2_idx;
    logic [RA_W-1:0]  rd_idx;
    logic [LAT_W-1:0] cnt [NREGS];

    assign opc     = if_instr[INSTR_W-1 -: OPC_W];
    assign src     = decode_src(opc, if_instr[3*FLD_W-1:0]);
    assign dst     = decode_dst(opc, if_instr[3*FLD_W-1:2*FLD_W]);
    assign rs1_idx = RA_W'(src.rs1);
    assign rs2_idx = RA_W'(src.rs2);
    assign rd_idx  = RA_W'(dst.rd);

    logic data_hz;
    logic ctrl_hz;

    assign data_hz = if_valid &&
                     ((src.use1 && (rs1_idx != '0) && (cnt[rs1_idx] != '0)) ||
                      (src.use2 && (rs2_idx != '0) && (cnt[rs2_idx] != '0)));
    assign stall       = data_hz | ctrl_hz;
    assign issue       = if_valid & ~stall;
    assign stall_cause = {ctrl_hz, data_hz};

    logic             ld_en;
    logic [LAT_W-1:0] ld_val;
    logic             rs_en;
    logic [LAT_W-1:0] rs_val;
    logic             save_vld_q, save_vld_d;
    logic [RA_W-1:0]  save_rd_q,  save_rd_d;
    logic [LAT_W-1:0] save_val_q, save_val_d;

    // Issue snapshot so a flush of the ID instruction can undo its load
    always_comb begin
        ld_en      = issue && dst.valid;
        ld_val     = (opc == OP_LW) ? LAT_W'(LOAD_LAT) : LAT_W'(ALU_EFF);
        save_vld_d = ld_en;
        save_rd_d  = rd_idx;
        save_val_d = sat_dec(cnt[rd_idx]);
        rs_en      = flush_id && save_vld_q;
        rs_val     = sat_dec(save_val_q);
    end

    assign cnt[0]       = '0;
    assign busy_mask[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        hazard_reg_counter #(
            .CW(LAT_W)
        ) u_cnt (
            .clk          (clk),
            .rst          (rst),
            .load_i       (ld_en && (rd_idx == RA_W'(r))),
            .load_val_i   (ld_val),
            .restore_i    (rs_en && (save_rd_q == RA_W'(r))),
            .restore_val_i(rs_val),
            .cnt_o        (cnt[r])
        );
        assign busy_mask[r] = (cnt[r] != '0);
    end

    ctrl_state_e      state_q, state_d;
    logic [PEN_W-1:0] pcnt_q,  pcnt_d;
    logic             first_q, first_d;
    logic [CNT_W-1:0] sc_q,    sc_d;

    // Control-transfer penalty FSM plus saturating stall counter
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        first_d = 1'b0;
        ctrl_hz = 1'b0;
        if (state_q == ST_WAIT) begin
            ctrl_hz = 1'b1;
            if ((flush_id && first_q) || (pcnt_q <= PEN_W'(1))) begin
                state_d = ST_IDLE;
                pcnt_d  = '0;
            end else begin
                pcnt_d = pcnt_q - PEN_W'(1);
            end
        end
        if (issue && (opc == OP_CALL) && (CALL_PEN != 0)) begin
            state_d = ST_WAIT;
            pcnt_d  = PEN_W'(CALL_PEN);
            first_d = 1'b1;
        end else if (issue && (opc == OP_RET) && (RET_PEN != 0)) begin
            state_d = ST_WAIT;
            pcnt_d  = PEN_W'(RET_PEN);
            first_d = 1'b1;
        end
        sc_d = sc_q;
        if (stall && (sc_q != '1)) begin
            sc_d = sc_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pcnt_q     <= '0;
            first_q    <= 1'b0;
            sc_q       <= '0;
            save_vld_q <= 1'b0;
            save_rd_q  <= '0;
            save_val_q <= '0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            first_q    <= first_d;
            sc_q       <= sc_d;
            save_vld_q <= save_vld_d;
            save_rd_q  <= save_rd_d;
            save_val_q <= save_val_d;
        end
    end

    assign stall_cycles = sc_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a default instance and a forwarding
// instance with a narrow stall counter, checked cycle by cycle.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] instr0, instr1;
    logic        valid0, valid1;
    logic        flush0, flush1;
    logic        stall0, stall1;
    logic        issue0, issue1;
    logic [1:0]  cause0, cause1;
    logic [15:0] busy0,  busy1;
    logic [15:0] sc0;
    logic [3:0]  sc1;

    int total = 0;
    int bad   = 0;
    int exp_sc0 = 0;
    int exp_sc1 = 0;

    typedef struct packed {
        logic       stall;
        logic [1:0] cause;
        logic       issue;
    } obs_t;

    obs_t  exp_q [$];
    string tag_q [$];

    hazard_scoreboard dut0 (
        .clk(clk), .rst(rst), .if_instr(instr0), .if_valid(valid0),
        .flush_id(flush0), .stall(stall0), .issue(issue0),
        .stall_cause(cause0), .busy_mask(busy0), .stall_cycles(sc0)
    );

    hazard_scoreboard #(.FWD_EN(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .if_instr(instr1), .if_valid(valid1),
        .flush_id(flush1), .stall(stall1), .issue(issue1),
        .stall_cause(cause1), .busy_mask(busy1), .stall_cycles(sc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end, expected finish");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c};
    endfunction

    // One cycle: drive, queue the expectation, compare at the falling edge
    task automatic cyc(input int sel, input logic v, input logic [15:0] ins,
                       input logic fl, input logic es, input logic [1:0] ec,
                       input string tag);
        obs_t  e;
        obs_t  o;
        string t;
        logic  r;
        r = rst;
        if (sel == 0) begin
            valid0 = v; instr0 = ins; flush0 = fl; valid1 = 1'b0; flush1 = 1'b0;
        end else begin
            valid1 = v; instr1 = ins; flush1 = fl; valid0 = 1'b0; flush0 = 1'b0;
        end
        e.stall = es;
        e.cause = ec;
        e.issue = v & ~es;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        o = (sel == 0) ? {stall0, cause0, issue0} : {stall1, cause1, issue1};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed stall/cause/issue=%b expected=%b", t, o, e);
        end
        @(posedge clk);
        #1;
        if (r) begin
            exp_sc0 = 0;
            exp_sc1 = 0;
        end else if (es) begin
            if (sel == 0) exp_sc0 = (exp_sc0 < 65535) ? exp_sc0 + 1 : 65535;
            else          exp_sc1 = (exp_sc1 < 15) ? exp_sc1 + 1 : 15;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drain(input int sel, input int n);
        for (int i = 0; i < n; i++) cyc(sel, 1'b0, 16'h0, 1'b0, 1'b0, CAUSE_NONE, "drain");
    endtask

    initial begin
        rst = 1'b1;
        instr0 = '0; instr1 = '0;
        valid0 = 1'b0; valid1 = 1'b0;
        flush0 = 1'b0; flush1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy0", 32'(busy0), 32'h0);
        chk("rst_sc0",   32'(sc0),   32'h0);
        chk("rst_sc1",   32'(sc1),   32'h0);
        rst = 1'b0;
        cyc(0, 1'b0, 16'h0, 1'b0, 1'b0, CAUSE_NONE, "rst_idle");

        // RAW on an ALU result
        cyc(0, 1'b1, enc(OP_ADD, 4'd3, 4'd1, 4'd2), 1'b0, 1'b0, CAUSE_NONE, "raw_prod");
        chk("raw_busy3", 32'(busy0), 32'h0008);
        cyc(0, 1'b1, enc(OP_ADD, 4'd4, 4'd3, 4'd3), 1'b0, 1'b1, CAUSE_DATA, "raw_s1");
        cyc(0, 1'b1, enc(OP_ADD, 4'd4, 4'd3, 4'd3), 1'b0, 1'b1, CAUSE_DATA, "raw_s2");
        cyc(0, 1'b1, enc(OP_ADD, 4'd4, 4'd3, 4'd3), 1'b0, 1'b0, CAUSE_NONE, "raw_go");
        chk("raw_sc", 32'(sc0), 32'(exp_sc0));
        chk("raw_busy4", 32'(busy0), 32'h0010);
        drain(0, 4);

        // RET and CALL penalties
        cyc(0, 1'b1, enc(OP_RET, 4'd0, 4'd0, 4'd0), 1'b0, 1'b0, CAUSE_NONE, "ret_issue");
        for (int i = 0; i < 3; i++)
            cyc(0, 1'b1, enc(OP_ADD, 4'd5, 4'd1, 4'd2), 1'b0, 1'b1, CAUSE_CTRL, "ret_pen");
        cyc(0, 1'b1, enc(OP_ADD, 4'd5, 4'd1, 4'd2), 1'b0, 1'b0, CAUSE_NONE, "ret_done");
        drain(0, 4);
        cyc(0, 1'b1, enc(OP_CALL, 4'd0, 4'd0, 4'd0), 1'b0, 1'b0, CAUSE_NONE, "call_issue");
        cyc(0, 1'b1, enc(OP_ADD, 4'd6, 4'd1, 4'd2), 1'b0, 1'b1, CAUSE_CTRL, "call_pen");
        cyc(0, 1'b1, enc(OP_ADD, 4'd6, 4'd1, 4'd2), 1'b0, 1'b0, CAUSE_NONE, "call_done");
        drain(0, 4);

        // Control stall still reported behind bubbles
        cyc(0, 1'b1, enc(OP_RET, 4'd0, 4'd0, 4'd0), 1'b0, 1'b0, CAUSE_NONE, "retb_issue");
        for (int i = 0; i < 3; i++)
            cyc(0, 1'b0, enc(OP_ADD, 4'd6, 4'd15, 4'd2), 1'b0, 1'b1, CAUSE_CTRL, "retb_pen");
        cyc(0, 1'b0, enc(OP_ADD, 4'd6, 4'd15, 4'd2), 1'b0, 1'b0, CAUSE_NONE, "retb_end");
        chk("retb_sc", 32'(sc0), 32'(exp_sc0));
        drain(0, 2);

        // Both causes: reader of the link register behind RET
        cyc(0, 1'b1, enc(OP_RET, 4'd0, 4'd0, 4'd0), 1'b0, 1'b0, CAUSE_NONE, "both_issue");
        cyc(0, 1'b1, enc(OP_ADD, 4'd1, 4'd15, 4'd2), 1'b0, 1'b1, CAUSE_BOTH, "both_1");
        cyc(0, 1'b1, enc(OP_ADD, 4'd1, 4'd15, 4'd2), 1'b0, 1'b1, CAUSE_BOTH, "both_2");
        cyc(0, 1'b1, enc(OP_ADD, 4'd1, 4'd15, 4'd2), 1'b0, 1'b1, CAUSE_CTRL, "both_3");
        cyc(0, 1'b1, enc(OP_ADD, 4'd1, 4'd15, 4'd2), 1'b0, 1'b0, CAUSE_NONE, "both_go");
        drain(0, 4);
        chk("both_sc", 32'(sc0), 32'(exp_sc0));

        // Flush of a fresh writer
        cyc(0, 1'b1, enc(OP_ADD, 4'd7, 4'd1, 4'd2), 1'b0, 1'b0, CAUSE_NONE, "fla_prod");
        cyc(0, 1'b1, enc(OP_ADD, 4'd8, 4'd7, 4'd1), 1'b1, 1'b1, CAUSE_DATA, "fla_flush");
        chk("fla_busy", 32'(busy0), 32'h0);
        cyc(0, 1'b1, enc(OP_ADD, 4'd8, 4'd7, 4'd1), 1'b0, 1'b0, CAUSE_NONE, "fla_reader");
        drain(0, 4);

        // Flush restores an older pending count of 2 to 0
        cyc(0, 1'b1, enc(OP_LW, 4'd7, 4'd0, 4'd0), 1'b0, 1'b0, CAUSE_NONE, "flb_lw");
        cyc(0, 1'b1, enc(OP_ADD, 4'd7, 4'd1, 4'd2), 1'b0, 1'b0, CAUSE_NONE, "flb_add");
        chk("flb_busy7", 32'(busy0), 32'h0080);
        cyc(0, 1'b1, enc(OP_ADD, 4'd8, 4'd7, 4'd1), 1'b1, 1'b1, CAUSE_DATA, "flb_flush");
        chk("flb_restore", 32'(busy0), 32'h0);
        cyc(0, 1'b1, enc(OP_ADD, 4'd8, 4'd7, 4'd1), 1'b0, 1'b0, CAUSE_NONE, "flb_reader");
        drain(0, 4);

        // Flushed RET: penalty cut after first cycle, link count restored
        cyc(0, 1'b1, enc(OP_RET, 4'd0, 4'd0, 4'd0), 1'b0, 1'b0, CAUSE_NONE, "flr_issue");
        cyc(0, 1'b1, enc(OP_ADD, 4'd2, 4'd15, 4'd3), 1'b1, 1'b1, CAUSE_BOTH, "flr_flush");
        cyc(0, 1'b1, enc(OP_ADD, 4'd2, 4'd15, 4'd3), 1'b0, 1'b0, CAUSE_NONE, "flr_go");
        drain(0, 4);

        // r0 is never a hazard; SW waits on r14
        cyc(0, 1'b1, enc(OP_LW, 4'd0, 4'd0, 4'd0), 1'b0, 1'b0, CAUSE_NONE, "r0_lw");
        chk("r0_busy", 32'(busy0), 32'h0);
        cyc(0, 1'b1, enc(OP_ADD, 4'd1, 4'd0, 4'd0), 1'b0, 1'b0, CAUSE_NONE, "r0_read");
        cyc(0, 1'b1, enc(OP_LW, 4'd14, 4'd0, 4'd0), 1'b0, 1'b0, CAUSE_NONE, "r14_lw");
        cyc(0, 1'b1, enc(OP_SW, 4'd2, 4'd0, 4'd0), 1'b0, 1'b1, CAUSE_DATA, "sw_s1");
        cyc(0, 1'b1, enc(OP_SW, 4'd2, 4'd0, 4'd0), 1'b0, 1'b1, CAUSE_DATA, "sw_s2");
        cyc(0, 1'b1, enc(OP_SW, 4'd2, 4'd0, 4'd0), 1'b0, 1'b0, CAUSE_NONE, "sw_go");
        chk("sw_busy", 32'(busy0), 32'h0);
        drain(0, 2);
        chk("sw_sc", 32'(sc0), 32'(exp_sc0));

        // Reset in the middle of a RET penalty with r9 pending
        cyc(0, 1'b1, enc(OP_ADD, 4'd9, 4'd1, 4'd2), 1'b0, 1'b0, CAUSE_NONE, "rs_prod");
        cyc(0, 1'b1, enc(OP_RET, 4'd0, 4'd0, 4'd0), 1'b0, 1'b0, CAUSE_NONE, "rs_ret");
        rst = 1'b1;
        cyc(0, 1'b0, 16'h0, 1'b0, 1'b1, CAUSE_CTRL, "rs_cycle");
        rst = 1'b0;
        chk("rs_busy", 32'(busy0), 32'h0);
        chk("rs_sc", 32'(sc0), 32'h0);
        cyc(0, 1'b1, enc(OP_ADD, 4'd10, 4'd9, 4'd9), 1'b0, 1'b0, CAUSE_NONE, "rs_after");
        drain(0, 4);

        // Forwarding instance: only load-use stalls
        cyc(1, 1'b1, enc(OP_ADD, 4'd3, 4'd1, 4'd2), 1'b0, 1'b0, CAUSE_NONE, "fwd_prod");
        cyc(1, 1'b1, enc(OP_ADD, 4'd4, 4'd3, 4'd3), 1'b0, 1'b0, CAUSE_NONE, "fwd_use");
        chk("fwd_busy", 32'(busy1), 32'h0);
        cyc(1, 1'b1, enc(OP_LW, 4'd5, 4'd0, 4'd0), 1'b0, 1'b0, CAUSE_NONE, "fwd_lw");
        cyc(1, 1'b1, enc(OP_ADD, 4'd6, 4'd5, 4'd5), 1'b0, 1'b1, CAUSE_DATA, "fwd_lu1");
        cyc(1, 1'b1, enc(OP_ADD, 4'd6, 4'd5, 4'd5), 1'b0, 1'b1, CAUSE_DATA, "fwd_lu2");
        cyc(1, 1'b1, enc(OP_ADD, 4'd6, 4'd5, 4'd5), 1'b0, 1'b0, CAUSE_NONE, "fwd_lu_go");
        chk("fwd_sc", 32'(sc1), 32'(exp_sc1));

        // Drive the 4-bit stall counter past its maximum
        for (int k = 0; k < 6; k++) begin
            cyc(1, 1'b1, enc(OP_RET, 4'd0, 4'd0, 4'd0), 1'b0, 1'b0, CAUSE_NONE, "sat_ret");
            for (int i = 0; i < 3; i++)
                cyc(1, 1'b0, 16'h0, 1'b0, 1'b1, CAUSE_CTRL, "sat_pen");
        end
        chk("sat_sc", 32'(sc1), 32'(exp_sc1));
        chk("sat_max", 32'(sc1), 32'h000F);
        drain(1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
